branch_metric_unit: RTL

- Sits directly downstream of the convolutional encoder, upstream of the radix-4 add-compare-select (ACS) array.
- Accepts one received 576-bit coded frame and slices it into one 6-bit radix-4 symbol pair per step.
- Each step, compares the symbol pair against all 1024 expected transition codewords (256 states x 4 branches) from the encoder and emits masked Hamming-distance branch metrics, with a valid/ready handshake to the ACS.

---
 rtl/branch_metric_unit_pkg.sv | 70 +++++++
 rtl/branch_metric_unit_bm_hamming.sv | 13 +
 rtl/branch_metric_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/branch_metric_unit_pkg.sv
// Shared sizes, FSM state type and popcount helper for the radix-4 branch metric unit.
// The macros mirror the codebase's param_def.sv values so this slice builds on its own.
`ifndef MAX_STATE_NUM
`define MAX_STATE_NUM 256
`endif
`ifndef RADIX
`define RADIX 4
`endif
`ifndef SLICED_INPUT_NUM
`define SLICED_INPUT_NUM 6
`endif
`ifndef MAX_CODE_RATE
`define MAX_CODE_RATE 3
`endif
`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif
`ifndef FRAME_BITS
`define FRAME_BITS 576
`endif
`ifndef NUM_STEPS
`define NUM_STEPS 96
`endif
`ifndef BM_WIDTH
`define BM_WIDTH 3
`endif
`ifndef RATE2_MASK
`define RATE2_MASK 6'b011011
`endif
`ifndef RATE3_MASK
`define RATE3_MASK 6'b111111
`endif

package branch_metric_unit_pkg;

    localparam int NUM_STATES = `MAX_STATE_NUM;
    localparam int NUM_BRANCH = `RADIX;
    localparam int SYM_W      = `SLICED_INPUT_NUM;
    localparam int MAX_RATE   = `MAX_CODE_RATE;
    localparam int FRAME_W    = `FRAME_BITS;
    localparam int NUM_STEPS  = `NUM_STEPS;
    localparam int BM_W       = `BM_WIDTH;
    localparam int STEP_W     = 7;

    localparam logic              RATE_2     = `CODE_RATE_2;
    localparam logic              RATE_3     = `CODE_RATE_3;
    localparam logic [SYM_W-1:0]  MASK_R2    = `RATE2_MASK;
    localparam logic [SYM_W-1:0]  MASK_R3    = `RATE3_MASK;
    localparam logic [STEP_W-1:0] LAST_STEP  = 7'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLICE = 2'd1,
        OUT   = 2'd2,
        DONE  = 2'd3
    } bm_state_t;

    function automatic logic [BM_W-1:0] popcount6(input logic [SYM_W-1:0] v);
        logic [BM_W-1:0] cnt;
        cnt = 3'd0;
        for (int k = 0; k < SYM_W; k++) begin
            cnt = cnt + {2'b00, v[k]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/branch_metric_unit_bm_hamming.sv
// Masked Hamming distance between a received radix-4 symbol pair and one expected codeword.
module bm_hamming
    import branch_metric_unit_pkg::*;
(
    input  logic [SYM_W-1:0] rx_i,
    input  logic [SYM_W-1:0] trans_i,
    input  logic [SYM_W-1:0] mask_i,
    output logic [BM_W-1:0]  dist_o
);

    assign dist_o = popcount6((rx_i ^ trans_i) & mask_i);

endmodule

// File: rtl/branch_metric_unit.sv
// Radix-4 branch metric unit: slices a latched coded frame into symbol pairs and
// streams 256x4 masked Hamming metrics per step to the ACS array over valid/ready.
module branch_metric_unit
    import branch_metric_unit_pkg::*;
(
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            en_bm,
    input  logic                                            i_code_rate,
    input  logic [FRAME_W-1:0]                              i_rx_data,
    input  logic                                            i_rx_valid,
    output logic                                            o_rx_ready,
    input  logic [NUM_STATES-1:0][NUM_BRANCH-1:0][SYM_W-1:0] i_trans_data,
    output logic [NUM_STATES-1:0][NUM_BRANCH-1:0][BM_W-1:0]  o_branch_metric,
    output logic                                            o_bm_valid,
    input  logic                                            i_bm_ready,
    output logic [STEP_W-1:0]                               o_step_idx,
    output logic                                            o_last_step,
    output logic                                            o_frame_done
);

    bm_state_t                                        state_q, state_d;
    logic [STEP_W-1:0]                                step_q, step_d;
    logic [FRAME_W-1:0]                               frame_q, frame_d;
    logic                                             rate_q, rate_d;
    logic [NUM_STATES-1:0][NUM_BRANCH-1:0][BM_W-1:0]  bm_q, bm_d;
    logic                                             bm_valid_q, bm_valid_d;
    logic                                             last_q, last_d;
    logic                                             done_q, done_d;
    logic                                             rx_ready_q, rx_ready_d;
    logic [STEP_W-1:0]                                step_idx_q, step_idx_d;

    logic [SYM_W-1:0]                                 rx_s;
    logic [SYM_W-1:0]                                 mask_s;
    logic [NUM_STATES-1:0][NUM_BRANCH-1:0][BM_W-1:0]  metric_s;

    // The frame shifts left after every beat, so the current symbol pair always sits at the top.
    always_comb begin
        if (rate_q == RATE_3) begin
            rx_s   = {frame_q[FRAME_W-6], frame_q[FRAME_W-5], frame_q[FRAME_W-4],
                      frame_q[FRAME_W-3], frame_q[FRAME_W-2], frame_q[FRAME_W-1]};
            mask_s = MASK_R3;
        end else begin
            rx_s   = {1'b0, frame_q[FRAME_W-4], frame_q[FRAME_W-3],
                      1'b0, frame_q[FRAME_W-2], frame_q[FRAME_W-1]};
            mask_s = MASK_R2;
        end
    end

    for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_state
        for (genvar gj = 0; gj < NUM_BRANCH; gj++) begin : g_branch
            bm_hamming u_ham (
                .rx_i    (rx_s),
                .trans_i (i_trans_data[gi][gj]),
                .mask_i  (mask_s),
                .dist_o  (metric_s[gi][gj])
            );
        end
    end

    // Next-state and next-output logic for the load/slice/handshake sequence.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        frame_d    = frame_q;
        rate_d     = rate_q;
        bm_d       = bm_q;
        bm_valid_d = bm_valid_q;
        last_d     = last_q;
        done_d     = 1'b0;
        rx_ready_d = rx_ready_q;
        step_idx_d = step_idx_q;
        case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    frame_d    = i_rx_data;
                    rate_d     = i_code_rate;
                    step_d     = 7'd0;
                    rx_ready_d = 1'b0;
                    state_d    = SLICE;
                end else begin
                    rx_ready_d = 1'b1;
                end
            end
            SLICE: begin
                bm_d       = metric_s;
                bm_valid_d = 1'b1;
                step_idx_d = step_q;
                last_d     = (step_q == LAST_STEP);
                state_d    = OUT;
            end
            OUT: begin
                if (i_bm_ready) begin
                    bm_valid_d = 1'b0;
                    last_d     = 1'b0;
                    if (step_q == LAST_STEP) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        step_d  = step_q + 7'd1;
                        frame_d = (rate_q == RATE_3) ? {frame_q[FRAME_W-7:0], 6'b000000}
                                                     : {frame_q[FRAME_W-5:0], 4'b0000};
                        state_d = SLICE;
                    end
                end else begin
                    state_d = OUT;
                end
            end
            DONE: begin
                rx_ready_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                rx_ready_d = 1'b1;
                bm_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and output registers: reset wins, en_bm low freezes everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            step_q     <= 7'd0;
            frame_q    <= '0;
            rate_q     <= 1'b0;
            bm_q       <= '0;
            bm_valid_q <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_ready_q <= 1'b1;
            step_idx_q <= 7'd0;
        end else if (en_bm) begin
            state_q    <= state_d;
            step_q     <= step_d;
            frame_q    <= frame_d;
            rate_q     <= rate_d;
            bm_q       <= bm_d;
            bm_valid_q <= bm_valid_d;
            last_q     <= last_d;
            done_q     <= done_d;
            rx_ready_q <= rx_ready_d;
            step_idx_q <= step_idx_d;
        end
    end

    assign o_rx_ready      = rx_ready_q;
    assign o_branch_metric = bm_q;
    assign o_bm_valid      = bm_valid_q;
    assign o_step_idx      = step_idx_q;
    assign o_last_step     = last_q;
    assign o_frame_done    = done_q;

endmodule
